einstein_ps2_matrix: RTL
========================

// Module: einstein_ps2_matrix
// PURPOSE
//  PS/2 keyboard front end for the Einstein core. Deserialises raw PS/2 frames and tracks the make/break state
//  of an 8x8 key matrix plus the SHIFT/CTRL/GRAPH lines. Answers the PSG port-A row strobe (kb_row) with the
//  column pattern (kb_col) that the PSG reads on port B. Sits directly upstream of the machine top level.
// PARAMETERS
//  FILTER_LEN  8      clk_sys cycles ps2_clk/ps2_data must be stable before the filtered level changes
//  TIMEOUT     32000  clk_sys cycles with no falling ps2_clk edge before a partial frame is dropped (1 ms @32 MHz)
// PORTS
//  clk_sys    in   1  system clock, 32 MHz; the single clock domain
//  reset      in   1  asynchronous, active-high reset
//  ps2_clk    in   1  raw PS/2 clock (asynchronous)
//  ps2_data   in   1  raw PS/2 data (asynchronous)
//  kb_row     in   8  row select from PSG port A, active low; several rows may be low at once
//  kb_col     out  8  column readback to PSG port B, active low; registered
//  kb_shift   out  1  0 while either SHIFT (0x12, 0x59) is held
//  kb_ctrl    out  1  0 while either CTRL (0x14, E0 14) is held
//  kb_graph   out  1  0 while GRAPH (0x11 left Alt) is held
//  kb_event   out  1  one-cycle pulse whenever any matrix bit or modifier changes
//  frame_err  out  1  one-cycle pulse when a frame is rejected (stop bit, parity or timeout)
// BEHAVIOUR
//  Reset: all keys released; kb_col=8'hFF; kb_shift, kb_ctrl, kb_graph = 1; kb_event, frame_err = 0.
//   Prefix flags cleared; RX FSM in IDLE; bit counter 0.
//  Input conditioning: 2-FF synchroniser on each line, then a FILTER_LEN stability filter.
//   A falling edge of the filtered clock samples the filtered data.
//  RX FSM, advanced on each filtered falling edge:
//   IDLE   - data=0 -> DATA with cnt=0; data=1 -> stay in IDLE and pulse frame_err.
//   DATA   - shift in 8 bits, LSB first -> PARITY after the 8th bit.
//   PARITY - store the parity bit -> STOP.
//   STOP   - data=1 (and parity passes, see CONFIGURATION) -> byte valid next cycle, return to IDLE.
//            Otherwise pulse frame_err, discard the byte, return to IDLE.
//  Timeout: a counter runs while the FSM is not IDLE and clears on each falling edge.
//   At TIMEOUT it forces IDLE, pulses frame_err and clears the E0/F0 flags.
//  Byte decode, one cycle after byte valid:
//   0xE0 sets ext. 0xF0 sets brk. 0xE1 is discarded with no state change.
//   Any other byte: look up {ext, code} in the einstein_keymap.vh function, which returns {hit, mod[1:0], row[2:0], col[2:0]}.
//    mod != 0 updates the modifier; otherwise matrix[row][col] <= ~brk. A miss is ignored.
//    ext and brk are then cleared.
//   Fixed map entries: 0x1C 'A' -> row 2 col 1; 0x5A RETURN -> row 0 col 7; E0 75 UP -> row 5 col 3.
//   Make of an already-held key (typematic) changes nothing and raises no kb_event.
//  Column output, registered every cycle:
//   kb_col[c] = ~OR over r of (matrix[r][c] & ~kb_row[r]).
//   Latency is 1 clk from a kb_row change, and 2 clk from the stop-bit edge to matrix/kb_col.
//  Simultaneous events: a matrix update and a kb_row change in the same cycle are both reflected in the next kb_col.
//  Reset mid-frame: everything returns to reset values. The remainder of the frame is rejected at its next
//   falling edge, or by timeout.
// CONFIGURATION
//  KB_PARITY_CHECK_EN defined:   odd parity over data+parity is required; a bad frame is discarded
//   and pulses frame_err.
//  KB_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored; only the start and stop bits are checked.
// TESTING
//  1. kb_row=8'hFB, send 1C -> kb_col=8'hFD within 2 clk of the stop edge, kb_event=1 for 1 clk.
//     Send F0 1C -> kb_col=8'hFF.
//  2. Hold 'A'. kb_row=8'hFF -> kb_col=8'hFF. kb_row=8'h00 -> 8'hFD after 1 clk. kb_row=8'hFE -> 8'hFF.
//  3. Send 12, then 59, then F0 12 -> kb_shift stays 0. Send F0 59 -> kb_shift=1.
//     Send E0 14 -> kb_ctrl=0. Send 11 -> kb_graph=0.
//  4. Frame 1C with bad parity: with the macro -> kb_col unchanged and frame_err pulses;
//     without the macro -> 'A' registered.
//  5. Send 5 bits, idle 2 ms -> frame_err pulses. Then send a clean 1C -> 'A' registered correctly.
//  6. Assert reset after 4 bits of a frame, with 'A' held -> kb_col=8'hFF and modifiers = 1 immediately.
//     After timeout, 1C is decoded normally.

Source files
------------

// File: rtl/einstein_ps2_matrix.sv
// PS/2 keyboard front end: frame receiver, scan-code decoder and 8x8 key matrix with SHIFT/CTRL/GRAPH lines.
// Optional build macro KB_PARITY_CHECK_EN enables odd-parity rejection of received frames.
module einstein_ps2_matrix #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 32000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] kb_row,
  output logic [7:0] kb_col,
  output logic       kb_shift,
  output logic       kb_ctrl,
  output logic       kb_graph,
  output logic       kb_event,
  output logic       frame_err
);

`ifdef KB_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  // keymap entry: {hit, mod[1:0], row[2:0], col[2:0]}; mod 1=SHIFT 2=CTRL 3=GRAPH
  function automatic logic [8:0] m(input logic [5:0] rc);
    return {3'b100, rc};
  endfunction

  function automatic logic [8:0] keymap(input logic [8:0] key);
    case (key)
      9'h016: keymap = m(6'o00);  9'h01E: keymap = m(6'o01);  9'h026: keymap = m(6'o02);  9'h025: keymap = m(6'o03);
      9'h02E: keymap = m(6'o04);  9'h036: keymap = m(6'o05);  9'h076: keymap = m(6'o06);  9'h05A: keymap = m(6'o07);
      9'h03D: keymap = m(6'o10);  9'h03E: keymap = m(6'o11);  9'h046: keymap = m(6'o12);  9'h045: keymap = m(6'o13);
      9'h04E: keymap = m(6'o14);  9'h055: keymap = m(6'o15);  9'h066: keymap = m(6'o16);  9'h00D: keymap = m(6'o17);
      9'h015: keymap = m(6'o20);  9'h01C: keymap = m(6'o21);  9'h01A: keymap = m(6'o22);  9'h01D: keymap = m(6'o23);
      9'h01B: keymap = m(6'o24);  9'h022: keymap = m(6'o25);  9'h024: keymap = m(6'o26);  9'h023: keymap = m(6'o27);
      9'h021: keymap = m(6'o30);  9'h02D: keymap = m(6'o31);  9'h02B: keymap = m(6'o32);  9'h02A: keymap = m(6'o33);
      9'h02C: keymap = m(6'o34);  9'h034: keymap = m(6'o35);  9'h032: keymap = m(6'o36);  9'h035: keymap = m(6'o37);
      9'h033: keymap = m(6'o40);  9'h031: keymap = m(6'o41);  9'h03C: keymap = m(6'o42);  9'h03B: keymap = m(6'o43);
      9'h03A: keymap = m(6'o44);  9'h043: keymap = m(6'o45);  9'h042: keymap = m(6'o46);  9'h041: keymap = m(6'o47);
      9'h044: keymap = m(6'o50);  9'h04B: keymap = m(6'o51);  9'h049: keymap = m(6'o52);  9'h175: keymap = m(6'o53);
      9'h172: keymap = m(6'o54);  9'h16B: keymap = m(6'o55);  9'h174: keymap = m(6'o56);  9'h04D: keymap = m(6'o57);
      9'h04C: keymap = m(6'o60);  9'h04A: keymap = m(6'o61);  9'h054: keymap = m(6'o62);  9'h05B: keymap = m(6'o63);
      9'h052: keymap = m(6'o64);  9'h05D: keymap = m(6'o65);  9'h029: keymap = m(6'o66);  9'h058: keymap = m(6'o67);
      9'h005: keymap = m(6'o70);  9'h006: keymap = m(6'o71);  9'h004: keymap = m(6'o72);  9'h00C: keymap = m(6'o73);
      9'h003: keymap = m(6'o74);  9'h00B: keymap = m(6'o75);  9'h083: keymap = m(6'o76);  9'h00A: keymap = m(6'o77);
      9'h012, 9'h059: keymap = {3'b101, 6'o00};
      9'h014, 9'h114: keymap = {3'b110, 6'o00};
      9'h011:         keymap = {3'b111, 6'o00};
      default:        keymap = 9'h000;
    endcase
  endfunction

  logic [1:0]      csync_q, csync_d, dsync_q, dsync_d;
  logic            fclk_q, fclk_d, fdat_q, fdat_d, fclk_prev_q;
  logic [FW-1:0]   fccnt_q, fccnt_d, fdcnt_q, fdcnt_d;
  rx_state_e       state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_ok_q, par_ok_d, bvld_q, bvld_d, ferr_q, ferr_d;
  logic [TW-1:0]   to_q, to_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [7:0][7:0] mat_q, mat_d;
  // {graph, ctrl_r, ctrl_l, shift_r, shift_l}
  logic [4:0]      mods_q, mods_d;
  logic [7:0]      col_q, col_d;
  logic            event_q, event_d;
  logic            fall, timeout;
  logic [8:0]      km;

  assign fall    = fclk_prev_q & ~fclk_q;
  assign timeout = (state_q != IDLE) && !fall && (to_q == TW'(TIMEOUT - 1));
  assign km      = keymap({ext_q, sh_q});

  // Synchronise, then only accept a level once it has been stable for FILTER_LEN cycles
  always_comb begin
    csync_d = {csync_q[0], ps2_clk};
    dsync_d = {dsync_q[0], ps2_data};
    fclk_d  = fclk_q;
    fdat_d  = fdat_q;
    fccnt_d = '0;
    fdcnt_d = '0;
    if (csync_q[1] != fclk_q) begin
      fccnt_d = fccnt_q + 1'b1;
      if (fccnt_q == FW'(FILTER_LEN - 1)) begin
        fclk_d  = csync_q[1];
        fccnt_d = '0;
      end
    end
    if (dsync_q[1] != fdat_q) begin
      fdcnt_d = fdcnt_q + 1'b1;
      if (fdcnt_q == FW'(FILTER_LEN - 1)) begin
        fdat_d  = dsync_q[1];
        fdcnt_d = '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    par_ok_d = par_ok_q;
    bvld_d   = 1'b0;
    ferr_d   = 1'b0;
    to_d     = (state_q == IDLE || fall) ? '0 : to_q + 1'b1;
    if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      to_d    = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!fdat_q) begin
            state_d = DATA;
            cnt_d   = 3'd0;
          end else begin
            ferr_d = 1'b1;
          end
        end
        DATA: begin
          sh_d  = {fdat_q, sh_q[7:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ~PAR_CHK | (^{sh_q, fdat_q});
          state_d  = STOP;
        end
        default: begin
          state_d = IDLE;
          if (fdat_q && par_ok_q) bvld_d = 1'b1;
          else                    ferr_d = 1'b1;
        end
      endcase
    end
  end

  // Scan-code decode; kb_col is built from the next matrix so both updates land together
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    mat_d  = mat_q;
    mods_d = mods_q;
    if (timeout) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (bvld_q) begin
      if (sh_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (sh_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (sh_q != 8'hE1) begin
        if (km[8]) begin
          case (km[7:6])
            2'd1:    if (sh_q == 8'h59) mods_d[1] = ~brk_q; else mods_d[0] = ~brk_q;
            2'd2:    if (ext_q) mods_d[3] = ~brk_q; else mods_d[2] = ~brk_q;
            2'd3:    mods_d[4] = ~brk_q;
            default: mat_d[km[5:3]][km[2:0]] = ~brk_q;
          endcase
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    event_d = (mat_d != mat_q) || (mods_d != mods_q);
    for (int c = 0; c < 8; c++) begin
      col_d[c] = 1'b1;
      for (int r = 0; r < 8; r++)
        if (mat_d[r][c] && !kb_row[r]) col_d[c] = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      csync_q     <= 2'b11;
      dsync_q     <= 2'b11;
      fclk_q      <= 1'b1;
      fdat_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      fccnt_q     <= '0;
      fdcnt_q     <= '0;
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      sh_q        <= 8'h00;
      par_ok_q    <= 1'b0;
      bvld_q      <= 1'b0;
      ferr_q      <= 1'b0;
      to_q        <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      mat_q       <= '0;
      mods_q      <= '0;
      col_q       <= 8'hFF;
      event_q     <= 1'b0;
    end else begin
      csync_q     <= csync_d;
      dsync_q     <= dsync_d;
      fclk_q      <= fclk_d;
      fdat_q      <= fdat_d;
      fclk_prev_q <= fclk_q;
      fccnt_q     <= fccnt_d;
      fdcnt_q     <= fdcnt_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      par_ok_q    <= par_ok_d;
      bvld_q      <= bvld_d;
      ferr_q      <= ferr_d;
      to_q        <= to_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      mat_q       <= mat_d;
      mods_q      <= mods_d;
      col_q       <= col_d;
      event_q     <= event_d;
    end
  end

  assign kb_col    = col_q;
  assign kb_shift  = ~(mods_q[0] | mods_q[1]);
  assign kb_ctrl   = ~(mods_q[2] | mods_q[3]);
  assign kb_graph  = ~mods_q[4];
  assign kb_event  = event_q;
  assign frame_err = ferr_q;

endmodule
